ppfifo_get_initiator: RTL and testbench
=======================================

// Module: ppfifo_get_initiator
// PURPOSE
//  Get-side initiator for the push-pull FIFO protocol. Issues get_req to a PushPullFIFO and
//  captures get_value on get_ack. Buffers up to 2 words and re-presents them on a downstream
//  valid/ready stream. Sits between the FIFO read port and Hamming datapath consumers.
//  Reports delivered-word count, a stalled source and protocol violations.
// PARAMETERS
//  FIFO_WORD_SIZE  1   data width in bits (same as FIFO get_value)
//  COUNT_BITS      16  width of word_count
//  STALL_CYCLES    64  consecutive unacked get_req cycles before stalled asserts (>=1)
// PORTS
//  clock        in   1               single clock, all state updates on posedge
//  clear        in   1               synchronous, active-high reset
//  enable       in   1               1 = allowed to request new words
//  get_req      out  1               registered; request one word from FIFO
//  get_ack      in   1               1-cycle pulse; get_value valid in that cycle
//  get_value    in   FIFO_WORD_SIZE  word returned by FIFO
//  out_valid    out  1               head word available
//  out_ready    in   1               downstream accepts head word this cycle
//  out_value    out  FIFO_WORD_SIZE  head word
//  word_count   out  COUNT_BITS      words delivered downstream (out_valid & out_ready)
//  stalled      out  1               get_req held STALL_CYCLES cycles with no ack
//  proto_error  out  1               sticky; get_ack seen while get_req low
// BEHAVIOUR
//  Reset (clear=1 at posedge): get_req=0, out_valid=0, out_value=0, word_count=0, stalled=0,
//   proto_error=0, occupancy=EMPTY, stall counter=0. get_ack in a clear cycle is discarded.
//  Protocol: an ack counts only if get_req=1 in the same cycle. At most one word per ack.
//   Back-to-back acks are legal while get_req stays high.
//  Occupancy FSM EMPTY/ONE/TWO. Transitions:
//   push = get_ack & get_req; pop = out_valid & out_ready.
//   EMPTY: push -> ONE.
//   ONE: push&!pop -> TWO; pop&!push -> EMPTY; push&pop -> ONE (new word becomes head).
//   TWO: pop -> ONE. push cannot occur in TWO because get_req=0.
//  get_req next = enable & !clear & (occupancy_next != TWO). Registered, so it deasserts the
//   cycle after FIFO fill reaches TWO. Buffer overflow is impossible by construction.
//  Latency: ack in cycle N gives out_valid=1 in N+1 with out_value = that word (EMPTY case).
//   Order is strict FIFO.
//  out_value/out_valid are registered. out_value holds steady while out_valid & !out_ready.
//  enable falling: get_req drops next cycle. An ack in the cycle enable falls (get_req still 1)
//   is accepted.
//  word_count: +1 per pop, wraps 2^COUNT_BITS-1 -> 0.
//  Stall counter:
//   +1 each cycle with get_req & !get_ack, saturates at STALL_CYCLES.
//   Reset to 0 on ack or when get_req=0.
//   stalled = (counter == STALL_CYCLES).
//  proto_error: set on get_ack & !get_req, cleared only by clear. The stray word is dropped
//   and occupancy is unchanged.
//  Clear mid-operation: buffered words are lost, outputs go to reset values next cycle, and an
//   in-flight request is abandoned.
// STRUCTURE
//  Shared package ppfifo_rtl_pkg: occupancy enum {OCC_EMPTY, OCC_ONE, OCC_TWO}.
//   FIFO_WIDTH stays in constants.sv.
//  Sub-module ppfifo_skid_buffer2: 2-entry register buffer with push/pop/occupancy.
//   Top level holds the request, stall and count logic.
// TESTING (bench on ppfifo_if, FIFO_WORD_SIZE=8, STALL_CYCLES=4, PushPullFIFO depth 4)
//  1 Stream: enable=1, out_ready=1, put 0x11,0x22,0x33 ->
//    out_value 0x11,0x22,0x33 in order; word_count=3; out_valid one cycle after each get_ack.
//  2 Backpressure: out_ready=0, put 5 words -> exactly 2 acks taken; get_req=0 after 2nd ack;
//    out_value=first word held. Then out_ready=1 -> all 5 delivered in order.
//  3 Empty source: enable=1, FIFO empty -> get_req=1, stalled=1 after 4 cycles.
//    Put 0xA5 -> ack, stalled=0 next cycle, out_value=0xA5.
//  4 Clear mid-op: 2 words buffered, pulse clear ->
//    next cycle out_valid=0, get_req=0, word_count=0; old words never appear downstream.
//  5 Protocol: force get_ack=1 while get_req=0 ->
//    proto_error=1 sticky, occupancy unchanged; cleared only by clear.
//  6 Wrap: COUNT_BITS=4, deliver 17 words -> word_count=1; simultaneous push/pop at ONE keeps
//    order.

Source files
------------

// File: rtl/ppfifo_rtl_pkg.sv
// Shared types for the push-pull FIFO get-side initiator.
package ppfifo_rtl_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/ppfifo_skid_buffer2.sv
// Two-entry register buffer: head is presented downstream, tail holds the second word.
module ppfifo_skid_buffer2
  import ppfifo_rtl_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] dout_o,
  output occ_e             occ_next_o
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push_i) begin
          head_d = din_i;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        // push with pop replaces the head in place, keeping FIFO order
        if (push_i && pop_i) begin
          head_d = din_i;
        end else if (push_i) begin
          tail_d = din_i;
          occ_d  = OCC_TWO;
        end else if (pop_i) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop_i) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign valid_o    = (occ_q != OCC_EMPTY);
  assign dout_o     = head_q;
  assign occ_next_o = occ_d;

endmodule

// File: rtl/ppfifo_get_initiator.sv
// Get-side initiator: requests words from a push-pull FIFO and re-presents them on a
// valid/ready stream, with delivered-word count, stall detection and protocol-error flag.
module ppfifo_get_initiator
  import ppfifo_rtl_pkg::*;
#(
  parameter int unsigned FIFO_WORD_SIZE = 1,
  parameter int unsigned COUNT_BITS     = 16,
  parameter int unsigned STALL_CYCLES   = 64
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      enable,
  output logic                      get_req,
  input  logic                      get_ack,
  input  logic [FIFO_WORD_SIZE-1:0] get_value,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FIFO_WORD_SIZE-1:0] out_value,
  output logic [COUNT_BITS-1:0]     word_count,
  output logic                      stalled,
  output logic                      proto_error
);

  localparam int unsigned          STALL_W   = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_CYCLES);

  logic                  get_req_q, get_req_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  perr_q, perr_d;
  logic                  push, pop;
  occ_e                  occ_next;

  assign push = get_ack & get_req_q;
  assign pop  = out_valid & out_ready;

  ppfifo_skid_buffer2 #(
    .WIDTH(FIFO_WORD_SIZE)
  ) u_buf (
    .clk_i      (clock),
    .clr_i      (clear),
    .push_i     (push),
    .din_i      (get_value),
    .pop_i      (pop),
    .valid_o    (out_valid),
    .dout_o     (out_value),
    .occ_next_o (occ_next)
  );

  always_comb begin
    // Looking at next occupancy keeps the request low once the buffer is about to fill
    get_req_d = enable & ~clear & (occ_next != OCC_TWO);
    count_d   = pop ? count_q + 1'b1 : count_q;
    perr_d    = perr_q | (get_ack & ~get_req_q);
    stall_d   = '0;
    if (get_req_q && !get_ack) begin
      stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      get_req_q <= 1'b0;
      stall_q   <= '0;
      count_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      get_req_q <= get_req_d;
      stall_q   <= stall_d;
      count_q   <= count_d;
      perr_q    <= perr_d;
    end
  end

  assign get_req     = get_req_q;
  assign word_count  = count_q;
  assign stalled     = (stall_q == STALL_MAX);
  assign proto_error = perr_q;

endmodule

// File: tb/tb_ppfifo_get_initiator.sv
// Randomised bench: a queue-based source feeds the initiator, a negedge monitor checks
// every output against a word-queue reference model.
module tb_ppfifo_get_initiator;

  localparam int W  = 8;
  localparam int CB = 4;
  localparam int SC = 4;

  logic          clock = 1'b0;
  logic          clear, enable, get_req, get_ack, out_valid, out_ready, stalled, proto_error;
  logic [W-1:0]  get_value, out_value;
  logic [CB-1:0] word_count;

  ppfifo_get_initiator #(
    .FIFO_WORD_SIZE(W),
    .COUNT_BITS    (CB),
    .STALL_CYCLES  (SC)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .enable      (enable),
    .get_req     (get_req),
    .get_ack     (get_ack),
    .get_value   (get_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .word_count  (word_count),
    .stalled     (stalled),
    .proto_error (proto_error)
  );

  always #5 clock = ~clock;

  int           checks    = 0;
  int           failures  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] src[$];
  bit           mon_en    = 1'b0;
  int           exp_wc    = 0;
  int           stall_cnt = 0;
  bit           exp_req   = 1'b0;
  bit           exp_perr  = 1'b0;
  bit           fresh     = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus per iteration; percentages control each input's activity.
  task automatic run(input int n, input int en_p, input int rdy_p, input int ack_p,
                     input int stray_p, input int clr_p, input bit refill);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      clear     = ($urandom_range(99) < clr_p);
      enable    = ($urandom_range(99) < en_p);
      out_ready = ($urandom_range(99) < rdy_p);
      if (refill && src.size() < 4) src.push_back(W'($urandom_range(255)));
      get_ack   = 1'b0;
      get_value = W'($urandom_range(255));
      if (get_req && src.size() > 0 && $urandom_range(99) < ack_p) begin
        get_ack   = 1'b1;
        get_value = src[0];
        if (!clear) begin
          void'(src.pop_front());
          exp_q.push_back(get_value);
        end
      end else if (!get_req && $urandom_range(99) < stray_p) begin
        get_ack = 1'b1;
      end
    end
  endtask

  always @(negedge clock) begin
    int occ;
    bit push, mpop;
    push = get_ack && exp_req && !clear;
    occ  = exp_q.size() - (push ? 1 : 0);
    if (mon_en) begin
      chk("out_valid", out_valid, occ > 0);
      chk("get_req", get_req, exp_req);
      chk("stalled", stalled, stall_cnt == SC);
      chk("proto_error", proto_error, exp_perr);
      chk("word_count", word_count, exp_wc);
      if (occ > 0) chk("out_value", out_value, exp_q[0]);
      else if (fresh) chk("out_value_reset", out_value, 0);
    end
    if (clear) begin
      exp_q.delete();
      exp_wc    = 0;
      stall_cnt = 0;
      exp_perr  = 1'b0;
      fresh     = 1'b1;
      exp_req   = 1'b0;
    end else begin
      mpop = (occ > 0) && out_ready;
      if (mpop) begin
        void'(exp_q.pop_front());
        exp_wc = (exp_wc + 1) % (1 << CB);
      end
      if (push) fresh = 1'b0;
      if (get_ack && !exp_req) exp_perr = 1'b1;
      stall_cnt = (exp_req && !get_ack) ? ((stall_cnt < SC) ? stall_cnt + 1 : SC) : 0;
      exp_req   = enable && ((occ + (push ? 1 : 0) - (mpop ? 1 : 0)) < 2);
    end
  end

  initial begin
    clear = 1'b1; enable = 1'b0; out_ready = 1'b0; get_ack = 1'b0; get_value = '0;
    repeat (2) @(posedge clock);
    #1;
    clear  = 1'b0;
    mon_en = 1'b1;

    // streaming, then backpressure, then release
    run(12, 100, 100, 100, 0, 0, 1);
    run(15, 100, 0, 100, 0, 0, 1);
    chk("bp_req_low", get_req, 0);
    chk("bp_valid", out_valid, 1);
    run(10, 100, 100, 100, 0, 0, 1);

    // empty source: stall, then a single word clears it
    src.delete();
    run(8, 100, 100, 0, 0, 0, 0);
    chk("stall_set", stalled, 1);
    src.push_back(8'hA5);
    run(3, 100, 100, 100, 0, 0, 0);
    chk("stall_clear", stalled, 0);

    // stray acks while not requesting; flag must stick until clear
    run(10, 0, 50, 0, 60, 0, 1);
    @(posedge clock);
    #1;
    get_ack = 1'b1;
    run(10, 100, 100, 80, 30, 0, 1);
    chk("perr_sticky", proto_error, 1);

    // clear with two words buffered
    run(5, 100, 0, 100, 0, 0, 1);
    run(1, 100, 0, 100, 0, 100, 1);
    run(1, 100, 0, 100, 0, 0, 1);
    chk("clr_valid", out_valid, 0);
    chk("clr_req", get_req, 0);
    chk("clr_count", word_count, 0);
    chk("clr_perr", proto_error, 0);

    // long random mix, then a clean stream long enough to wrap the counter
    run(3000, 80, 60, 60, 5, 2, 1);
    run(1, 100, 100, 100, 0, 100, 1);
    run(40, 100, 100, 100, 0, 0, 1);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) run(1, 0, 100, 0, 0, 0, 0);
    chk("drain", exp_q.size(), 0);
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
